pred_lt_3_pipe: RTL and testbench

- Fractional-delay long-term predictor (G.729 Pred_lt_3) for the adaptive-codebook path of the decoder (also reused by the encoder).
- Counterpart of the encoder's Interpol_3 block:
  - Interpol_3 evaluates one interpolated sample for the pitch search.
  - This block regenerates the full subframe excitation in place in scratch memory, using the 1/3-resolution inter_3l filter from constant memory.
- Writes L_SUBFR samples, then pulses done.

---
 rtl/pred_lt_3_pipe.sv | 238 +++++++++++++++++++++++
 tb/tb_pred_lt_3_pipe.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pred_lt_3_pipe.sv
// G.729 Pred_lt_3: regenerates one subframe of adaptive-codebook excitation in place
// with the 1/3-resolution inter_3l filter. One tap is fetched per cycle and MACs trail by two cycles.
module pred_lt_3_pipe #(
  parameter int L_SUBFR   = 40,
  parameter int L_INTER10 = 10,
  parameter int UP_SAMP   = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [11:0] exc,
  input  logic [15:0] T0,
  input  logic [15:0] frac,
  input  logic [11:0] inter_3l,
  output logic [11:0] scratchReadAddr,
  input  logic [31:0] scratchReadData,
  output logic [11:0] constReadAddr,
  input  logic [31:0] constReadData,
  output logic [11:0] scratchWriteAddr,
  output logic [31:0] scratchWriteData,
  output logic        scratchWriteEn,
  output logic        done
);

  localparam int NTAPS = 2 * L_INTER10;

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_FETCH, S_MAC, S_WRITE, S_NEXT, S_DONE
  } state_t;

  // Saturating s + L_mult(a, b); L_mult(-1.0, -1.0) clips to the positive maximum
  function automatic logic signed [31:0] l_mac(input logic signed [31:0] s,
                                               input logic signed [15:0] a,
                                               input logic signed [15:0] b);
    logic signed [31:0] prod;
    logic signed [31:0] p;
    logic signed [32:0] sum;
    prod = $signed({{16{a[15]}}, a}) * $signed({{16{b[15]}}, b});
    if ((a == 16'sh8000) && (b == 16'sh8000)) begin
      p = 32'sh7fff_ffff;
    end else begin
      p = prod <<< 1;
    end
    sum = {s[31], s} + {p[31], p};
    if (sum[32] != sum[31]) begin
      l_mac = sum[32] ? 32'sh8000_0000 : 32'sh7fff_ffff;
    end else begin
      l_mac = sum[31:0];
    end
  endfunction

  // round(): top half of sat(s + 0x8000), given s[31:15]; only the positive end can clip
  function automatic logic [15:0] round16(input logic [16:0] top);
    if ((top[16:1] == 16'h7fff) && top[0]) begin
      round16 = 16'h7fff;
    end else begin
      round16 = top[16:1] + {15'd0, top[0]};
    end
  endfunction

  state_t             state_q, state_d;
  logic [11:0]        exc_q, exc_d, t0_q, t0_d, base_q, base_d;
  logic               fneg_q, fneg_d, fodd_q, fodd_d;
  logic [11:0]        x0_q, x0_d, c1_q, c1_d, c2_q, c2_d;
  logic [5:0]         j_q, j_d;
  logic [4:0]         t_q, t_d;
  logic signed [31:0] acc_q, acc_d;
  logic               v1_q, v1_d, v2_q, v2_d;
  logic [11:0]        raddr_q, raddr_d, caddr_q, caddr_d, waddr_q, waddr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               we_q, we_d, done_q, done_d;

  logic [1:0]  fr;
  logic [11:0] x1, tap_off, coef_off;
  logic [15:0] rnd;
  logic        unused_ok;

  // fr = -frac folded into 0..2; frac = +1 also moves x0 back by one sample
  assign fr       = fodd_q ? (fneg_q ? 2'd1 : 2'd2) : 2'd0;
  assign x1       = x0_q + {6'd0, j_q};
  assign tap_off  = {8'd0, t_q[4:1]};
  assign coef_off = 12'(UP_SAMP) * tap_off;
  assign rnd      = round16(acc_q[31:15]);
  assign unused_ok = ^{scratchReadData[31:16], constReadData[31:16], T0[15:12], frac[14:1]};

  // Next-state, address generation and accumulator update
  always_comb begin
    state_d = state_q;
    exc_d   = exc_q;
    t0_d    = t0_q;
    base_d  = base_q;
    fneg_d  = fneg_q;
    fodd_d  = fodd_q;
    x0_d    = x0_q;
    c1_d    = c1_q;
    c2_d    = c2_q;
    j_d     = j_q;
    t_d     = t_q;
    raddr_d = raddr_q;
    caddr_d = caddr_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    done_d  = 1'b0;
    v1_d    = 1'b0;
    v2_d    = v1_q;
    if (v2_q) begin
      acc_d = l_mac(acc_q, $signed(scratchReadData[15:0]), $signed(constReadData[15:0]));
    end else begin
      acc_d = acc_q;
    end
    case (state_q)
      S_IDLE: begin
        if (start) begin
          exc_d   = exc;
          t0_d    = T0[11:0];
          base_d  = inter_3l;
          fneg_d  = frac[15];
          fodd_d  = frac[0];
          state_d = S_INIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_INIT: begin
        x0_d    = exc_q - t0_q - {11'd0, fodd_q & ~fneg_q};
        c1_d    = base_q + {10'd0, fr};
        c2_d    = base_q + 12'd3 - {10'd0, fr};
        j_d     = 6'd0;
        t_d     = 5'd0;
        acc_d   = 32'sd0;
        state_d = S_FETCH;
      end
      S_FETCH: begin
        // even taps walk back from x1 on the c1 phase, odd taps walk forward from x1+1 on c2
        if (t_q[0]) begin
          raddr_d = x1 + 12'd1 + tap_off;
          caddr_d = c2_q + coef_off;
        end else begin
          raddr_d = x1 - tap_off;
          caddr_d = c1_q + coef_off;
        end
        v1_d = 1'b1;
        if (t_q == 5'(NTAPS - 1)) begin
          t_d     = 5'd0;
          state_d = S_MAC;
        end else begin
          t_d     = t_q + 5'd1;
          state_d = S_FETCH;
        end
      end
      S_MAC: begin
        if (v1_q) begin
          state_d = S_MAC;
        end else begin
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        we_d    = 1'b1;
        waddr_d = exc_q + {6'd0, j_q};
        wdata_d = {{16{rnd[15]}}, rnd};
        state_d = S_NEXT;
      end
      S_NEXT: begin
        acc_d = 32'sd0;
        if (j_q == 6'(L_SUBFR - 1)) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          j_d     = j_q + 6'd1;
          state_d = S_FETCH;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      exc_q   <= 12'd0;
      t0_q    <= 12'd0;
      base_q  <= 12'd0;
      fneg_q  <= 1'b0;
      fodd_q  <= 1'b0;
      x0_q    <= 12'd0;
      c1_q    <= 12'd0;
      c2_q    <= 12'd0;
      j_q     <= 6'd0;
      t_q     <= 5'd0;
      acc_q   <= 32'sd0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      raddr_q <= 12'd0;
      caddr_q <= 12'd0;
      waddr_q <= 12'd0;
      wdata_q <= 32'd0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      exc_q   <= exc_d;
      t0_q    <= t0_d;
      base_q  <= base_d;
      fneg_q  <= fneg_d;
      fodd_q  <= fodd_d;
      x0_q    <= x0_d;
      c1_q    <= c1_d;
      c2_q    <= c2_d;
      j_q     <= j_d;
      t_q     <= t_d;
      acc_q   <= acc_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      raddr_q <= raddr_d;
      caddr_q <= caddr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      done_q  <= done_d;
    end
  end

  assign scratchReadAddr  = raddr_q;
  assign constReadAddr    = caddr_q;
  assign scratchWriteAddr = waddr_q;
  assign scratchWriteData = wdata_q;
  assign scratchWriteEn   = we_q;
  assign done             = done_q;

endmodule

// File: tb/tb_pred_lt_3_pipe.sv
// Bench for pred_lt_3_pipe: scratch/const memory models, an integer reference model of
// the predictor, and scenario tasks for arithmetic, in-place feedback and control edges.
module tb_pred_lt_3_pipe;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [11:0] exc, inter_3l;
  logic [15:0] T0, frac;
  logic [11:0] scratchReadAddr, constReadAddr, scratchWriteAddr;
  logic [31:0] scratchReadData, constReadData, scratchWriteData;
  logic        scratchWriteEn, done;

  always #5 clk = ~clk;

  pred_lt_3_pipe dut (
    .clk(clk), .reset(reset), .start(start), .exc(exc), .T0(T0), .frac(frac),
    .inter_3l(inter_3l), .scratchReadAddr(scratchReadAddr), .scratchReadData(scratchReadData),
    .constReadAddr(constReadAddr), .constReadData(constReadData),
    .scratchWriteAddr(scratchWriteAddr), .scratchWriteData(scratchWriteData),
    .scratchWriteEn(scratchWriteEn), .done(done)
  );

  int checks = 0;
  int errors = 0;
  int coef [31] = '{29443, 25207, 14701, 3143, -4402, -5850, -2783, 1211, 3130, 2259, 0,
                    -1652, -1666, -464, 756, 1099, 550, -245, -634, -451, 0,
                    308, 296, 78, -120, -165, -79, 34, 91, 70, 0};

  logic [15:0] smem [4096];
  logic [15:0] cmem [4096];
  logic [15:0] hist [4096];
  logic        load_req = 1'b0;

  int          exp_v [40];
  logic [11:0] got_addr [40];
  logic [31:0] got_data [40];
  int          nwr, ndone, lat, hz_viol;

  // Synchronous memories, one-cycle read latency, junk in the unused upper halves
  always @(posedge clk) begin
    if (load_req) begin
      for (int k = 0; k < 4096; k++) smem[k] <= hist[k];
    end else if (scratchWriteEn) begin
      smem[scratchWriteAddr] <= scratchWriteData[15:0];
    end
    scratchReadData <= {16'hA5A5, smem[scratchReadAddr]};
    constReadData   <= {16'h5A5A, cmem[constReadAddr]};
  end

  function automatic longint sat32(input longint v);
    if (v > 64'sd2147483647) return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
  endfunction

  // Whole-subframe reference: plain integer arithmetic with clamping, in-place history
  task automatic model(input int e, input int t0, input int fv);
    int m [4096];
    int fr, x0;
    longint s, r;
    for (int k = 0; k < 4096; k++) m[k] = int'($signed(hist[k]));
    fr = -fv;
    x0 = e - t0;
    if (fr < 0) begin fr = fr + 3; x0 = x0 - 1; end
    for (int j = 0; j < 40; j++) begin
      s = 0;
      for (int i = 0; i < 10; i++) begin
        s = sat32(s + sat32(longint'(2) * m[(x0 + j - i) & 4095] * coef[fr + 3 * i]));
        s = sat32(s + sat32(longint'(2) * m[(x0 + j + 1 + i) & 4095] * coef[3 - fr + 3 * i]));
      end
      r = sat32(s + 32768) >>> 16;
      m[(e + j) & 4095] = int'(r);
      exp_v[j] = int'(r);
    end
  endtask

  task automatic load_mem(input logic [11:0] base);
    for (int k = 0; k < 31; k++) cmem[(int'(base) + k) % 4096] = 16'(coef[k]);
    @(negedge clk); load_req = 1'b1;
    @(negedge clk); load_req = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // One call: load memories, pulse start, capture writes until done (bounded)
  task automatic run_call(input logic [11:0] e, input int t0, input int fv, input logic [11:0] base);
    logic [11:0] off;
    load_mem(base);
    model(int'(e), t0, fv);
    exc = e; T0 = 16'(t0); frac = 16'(fv); inter_3l = base;
    for (int k = 0; k < 40; k++) begin got_addr[k] = 12'hxxx; got_data[k] = 32'hxxxxxxxx; end
    start = 1'b1; @(negedge clk); start = 1'b0;
    nwr = 0; ndone = 0; lat = 0; hz_viol = 0;
    for (int cyc = 1; cyc <= 1100; cyc++) begin
      off = scratchReadAddr - exc;
      if ((off < 12'd40) && (int'(off) >= nwr)) hz_viol++;
      if (scratchWriteEn) begin
        if (nwr < 40) begin got_addr[nwr] = scratchWriteAddr; got_data[nwr] = scratchWriteData; end
        nwr++;
      end
      if (done) begin ndone++; lat = cyc; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({scratchWriteEn, done} !== 2'b00) begin
      errors++; $display("FAIL reset_strobes got %b want 00", {scratchWriteEn, done});
    end
    checks++;
    if ({scratchReadAddr, constReadAddr, scratchWriteAddr, scratchWriteData} !== 68'd0) begin
      errors++; $display("FAIL reset_buses got %h %h %h %h want 0", scratchReadAddr, constReadAddr, scratchWriteAddr, scratchWriteData);
    end
    reset = 1'b0;
  endtask

  task automatic test_zero();
    for (int k = 0; k < 4096; k++) hist[k] = 16'h0000;
    run_call(12'h200, 60, 0, 12'h100);
    checks++; if (ndone != 1) begin errors++; $display("FAIL zero_done got %0d want 1", ndone); end
    checks++; if (nwr != 40) begin errors++; $display("FAIL zero_nwr got %0d want 40", nwr); end
    checks++; if (lat > 1000) begin errors++; $display("FAIL zero_latency got %0d want <=1000", lat); end
    for (int j = 0; j < 40; j++) begin
      checks++;
      if ({got_addr[j], got_data[j]} !== {12'h200 + 12'(j), 32'h0}) begin
        errors++; $display("FAIL zero_out[%0d] got %h/%h want %h/00000000", j, got_addr[j], got_data[j], 12'h200 + 12'(j));
      end
    end
  endtask

  task automatic test_impulse();
    logic [15:0] e16;
    logic [31:0] want;
    for (int k = 0; k < 4096; k++) hist[k] = 16'h0000;
    hist[12'h200 - 12'd60] = 16'd16384;
    run_call(12'h200, 60, 0, 12'h100);
    checks++; if (nwr != 40) begin errors++; $display("FAIL impulse_nwr got %0d want 40", nwr); end
    checks++;
    if (got_data[0] !== 32'h00003982) begin errors++; $display("FAIL impulse_out[0] got %h want 00003982", got_data[0]); end
    for (int j = 1; j < 40; j++) begin
      e16  = (j < 10) ? 16'((coef[3 * j] * 32768 + 32768) >>> 16) : 16'h0000;
      want = {{16{e16[15]}}, e16};
      checks++;
      if (got_data[j] !== want) begin errors++; $display("FAIL impulse_out[%0d] got %h want %h", j, got_data[j], want); end
    end
  endtask

  task automatic test_saturation();
    logic [15:0] e16;
    logic [31:0] want;
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < 4096; k++) hist[k] = (pass == 0) ? 16'h7FFF : 16'h8000;
      run_call(12'h300, 60, 1, 12'h100);
      checks++; if (nwr != 40) begin errors++; $display("FAIL sat%0d_nwr got %0d want 40", pass, nwr); end
      for (int j = 0; j < 40; j++) begin
        e16  = 16'(exp_v[j]);
        want = {{16{e16[15]}}, e16};
        checks++;
        if (got_data[j] !== want) begin errors++; $display("FAIL sat%0d_out[%0d] got %h want %h", pass, j, got_data[j], want); end
        checks++;
        if (got_data[j][31] !== pass[0]) begin errors++; $display("FAIL sat%0d_sign[%0d] got %b want %b", pass, j, got_data[j][31], pass[0]); end
      end
    end
  endtask

  task automatic test_feedback();
    logic [15:0] e16;
    logic [31:0] want;
    do_reset();
    for (int k = 0; k < 4096; k++) hist[k] = 16'($urandom);
    run_call(12'h400, 20, -1, 12'h100);
    checks++; if (ndone != 1) begin errors++; $display("FAIL feedback_done got %0d want 1", ndone); end
    checks++; if (hz_viol != 0) begin errors++; $display("FAIL feedback_order got %0d early reads want 0", hz_viol); end
    for (int j = 0; j < 40; j++) begin
      e16  = 16'(exp_v[j]);
      want = {{16{e16[15]}}, e16};
      checks++;
      if ({got_addr[j], got_data[j]} !== {12'h400 + 12'(j), want}) begin
        errors++; $display("FAIL feedback_out[%0d] got %h/%h want %h/%h", j, got_addr[j], got_data[j], 12'h400 + 12'(j), want);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] e16;
    logic [31:0] want;
    logic [11:0] e, base;
    int t0, fv;
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 4096; k++)
        hist[k] = (r == 1) ? 16'(int'($urandom_range(0, 4000)) - 2000) : 16'($urandom);
      t0   = int'($urandom_range(20, 143));
      fv   = int'($urandom_range(0, 2)) - 1;
      e    = (r == 2) ? 12'hFF0 : 12'($urandom);
      base = (r == 3) ? 12'hFF8 : 12'($urandom_range(0, 4000));
      run_call(e, t0, fv, base);
      checks++; if (nwr != 40) begin errors++; $display("FAIL b2b%0d_nwr got %0d want 40", r, nwr); end
      for (int j = 0; j < 40; j++) begin
        e16  = 16'(exp_v[j]);
        want = {{16{e16[15]}}, e16};
        checks++;
        if ({got_addr[j], got_data[j]} !== {e + 12'(j), want}) begin
          errors++; $display("FAIL b2b%0d_out[%0d] T0=%0d frac=%0d got %h/%h want %h/%h", r, j, t0, fv, got_addr[j], got_data[j], e + 12'(j), want);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int wr, dn;
    for (int k = 0; k < 4096; k++) hist[k] = 16'($urandom);
    load_mem(12'h100);
    exc = 12'h300; T0 = 16'd50; frac = 16'd0; inter_3l = 12'h100;
    start = 1'b1; @(negedge clk); start = 1'b0;
    wr = 0;
    for (int cyc = 0; cyc < 1100; cyc++) begin
      if (scratchWriteEn) wr++;
      if (wr == 17) break;
      @(negedge clk);
    end
    checks++; if (wr != 17) begin errors++; $display("FAIL rstmid_reach got %0d writes want 17", wr); end
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    checks++;
    if ({scratchWriteEn, done, scratchWriteData} !== 34'd0) begin
      errors++; $display("FAIL rstmid_outputs got %b%b %h want 0", scratchWriteEn, done, scratchWriteData);
    end
    wr = 0; dn = 0;
    for (int cyc = 0; cyc < 1100; cyc++) begin
      if (scratchWriteEn) wr++;
      if (done) dn++;
      @(negedge clk);
    end
    checks++; if (wr != 0) begin errors++; $display("FAIL rstmid_writes got %0d want 0", wr); end
    checks++; if (dn != 0) begin errors++; $display("FAIL rstmid_done got %0d want 0", dn); end
  endtask

  task automatic test_start_held();
    int wr, dn;
    load_mem(12'h100);
    exc = 12'h500; T0 = 16'd77; frac = 16'hFFFF; inter_3l = 12'h100;
    start = 1'b1; repeat (3) @(negedge clk); start = 1'b0;
    wr = 0; dn = 0;
    for (int cyc = 0; cyc < 1100; cyc++) begin
      if (scratchWriteEn) wr++;
      if (done) dn++;
      @(negedge clk);
    end
    checks++; if (wr != 40) begin errors++; $display("FAIL held_writes got %0d want 40", wr); end
    checks++; if (dn != 1) begin errors++; $display("FAIL held_done got %0d want 1", dn); end
  endtask

  task automatic test_start_busy();
    int wr, dn;
    load_mem(12'h100);
    exc = 12'h600; T0 = 16'd33; frac = 16'd1; inter_3l = 12'h100;
    start = 1'b1; @(negedge clk); start = 1'b0;
    wr = 0; dn = 0;
    for (int cyc = 1; cyc <= 1100; cyc++) begin
      start = (cyc == 300);
      if (scratchWriteEn) wr++;
      if (done) begin dn++; break; end
      @(negedge clk);
    end
    start = 1'b1; @(negedge clk); start = 1'b0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (scratchWriteEn) wr++;
      if (done) dn++;
      @(negedge clk);
    end
    checks++; if (wr != 40) begin errors++; $display("FAIL busy_writes got %0d want 40", wr); end
    checks++; if (dn != 1) begin errors++; $display("FAIL busy_done got %0d want 1", dn); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; exc = 12'h000; T0 = 16'd0; frac = 16'd0; inter_3l = 12'h000;
    for (int k = 0; k < 4096; k++) begin cmem[k] = 16'h0000; hist[k] = 16'h0000; end
    test_reset();
    test_zero();
    test_impulse();
    test_saturation();
    test_feedback();
    test_back_to_back();
    test_reset_mid();
    test_start_held();
    test_start_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
